// File: rtl/stream_prefetch_buffer.sv
// stream_prefetch_buffer: next-N-line instruction prefetcher with a small
// fully-associative line buffer between the I-cache miss port and memory.
// Demand misses go to memory and arm a stream of DEGREE sequential prefetches
// that run only while both caches are idle. Buffer hits are served locally.
// Optional build macro PREFETCH_STATS_EN adds saturating hit/miss/eviction
// counters and a per-entry used bit.
module stream_prefetch_buffer #(
    parameter int LINE_BYTES = 32,
    parameter int DEPTH      = 4,
    parameter int DEGREE     = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    prefetch_enable,
    input  logic                    icache_read,
    input  logic [31:0]             icache_addr,
    output logic                    icache_resp,
    output logic [8*LINE_BYTES-1:0] icache_rdata,
    input  logic                    dcache_busy,
    output logic                    mem_read,
    output logic [31:0]             mem_addr,
    input  logic                    mem_resp,
    input  logic [8*LINE_BYTES-1:0] mem_rdata
`ifdef PREFETCH_STATS_EN
    ,
    output logic [31:0]             stat_hits,
    output logic [31:0]             stat_misses,
    output logic [31:0]             stat_evict_unused
`endif
);

    localparam int OFF = $clog2(LINE_BYTES);
    localparam int TW  = 32 - OFF;
    localparam int LW  = 8 * LINE_BYTES;
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = $clog2(DEGREE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HIT, S_DEMAND, S_PF_CHECK, S_PREFETCH
    } state_t;

    state_t          state_reg;
    logic            resp_reg;
    logic [LW-1:0]   rdata_reg;
    logic            mem_read_reg;
    logic [31:0]     mem_addr_reg;
    logic [TW-1:0]   base_reg;
    logic [CW-1:0]   cnt_reg;
    logic [PW-1:0]   ptr_reg;

    logic [DEPTH-1:0] valid_reg;
    logic [TW-1:0]    tag_reg  [DEPTH];
    logic [LW-1:0]    data_reg [DEPTH];

    logic [TW-1:0]    req_tag;
    logic [TW-1:0]    fill_tag;
    logic [DEPTH-1:0] hit_vec;
    logic [DEPTH-1:0] pf_vec;
    logic             hit_any;
    logic             pf_any;
    logic [PW-1:0]    hit_idx;
    logic             fill_we;
    logic             demand_done;
    logic             sim_hit;
    logic             unused_low_bits;

    assign req_tag         = icache_addr[31:OFF];
    assign fill_tag        = mem_addr_reg[31:OFF];
    assign unused_low_bits = ^icache_addr[OFF-1:0];

    // Per-entry tag compare for the demand lookup and the prefetch duplicate check.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign hit_vec[gi] = valid_reg[gi] && (tag_reg[gi] == req_tag);
            assign pf_vec[gi]  = valid_reg[gi] && (tag_reg[gi] == base_reg);
        end
    endgenerate

    assign hit_any = |hit_vec;
    assign pf_any  = |pf_vec;

    // Encode the single matching entry (insertion never creates duplicates).
    always_comb begin
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit_vec[i]) hit_idx = PW'(i);
        end
    end

    assign fill_we     = (state_reg == S_PREFETCH) && mem_resp;
    assign demand_done = (state_reg == S_DEMAND) && mem_resp;
    assign sim_hit     = fill_we && icache_read && (req_tag == fill_tag);

    // Memory completions are forwarded to the I-cache in the cycle they arrive.
    assign icache_resp  = resp_reg || demand_done || sim_hit;
    assign icache_rdata = (demand_done || sim_hit) ? mem_rdata : rdata_reg;
    assign mem_read     = mem_read_reg;
    assign mem_addr     = mem_addr_reg;

    // Line data storage: written only by prefetch fills, validity tracked separately.
    always_ff @(posedge clk) begin
        if (fill_we) data_reg[ptr_reg] <= mem_rdata;
    end

    // Entry valid/tag (and used) bits, written at the replacement pointer on fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= '0;
            for (int i = 0; i < DEPTH; i++) tag_reg[i] <= '0;
        end else if (fill_we) begin
            valid_reg[ptr_reg] <= 1'b1;
            tag_reg[ptr_reg]   <= fill_tag;
        end
    end

    // Control FSM: lookup, demand fetch and one-line-at-a-time stream prefetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            resp_reg     <= 1'b0;
            rdata_reg    <= '0;
            mem_read_reg <= 1'b0;
            mem_addr_reg <= '0;
            base_reg     <= '0;
            cnt_reg      <= '0;
            ptr_reg      <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (icache_read) begin
                        if (hit_any) begin
                            state_reg <= S_HIT;
                            resp_reg  <= 1'b1;
                            rdata_reg <= data_reg[hit_idx];
                        end else begin
                            state_reg    <= S_DEMAND;
                            mem_read_reg <= 1'b1;
                            mem_addr_reg <= {req_tag, {OFF{1'b0}}};
                        end
                    end else if ((cnt_reg != '0) && prefetch_enable && !dcache_busy) begin
                        state_reg <= S_PF_CHECK;
                    end
                end
                S_HIT: begin
                    resp_reg  <= 1'b0;
                    state_reg <= S_IDLE;
                end
                S_DEMAND: begin
                    if (mem_resp) begin
                        mem_read_reg <= 1'b0;
                        base_reg     <= fill_tag + TW'(1);
                        cnt_reg      <= CW'(DEGREE);
                        state_reg    <= S_IDLE;
                    end
                end
                S_PF_CHECK: begin
                    if (pf_any) begin
                        base_reg  <= base_reg + TW'(1);
                        cnt_reg   <= cnt_reg - CW'(1);
                        state_reg <= S_IDLE;
                    end else begin
                        mem_addr_reg <= {base_reg, {OFF{1'b0}}};
                        mem_read_reg <= 1'b1;
                        state_reg    <= S_PREFETCH;
                    end
                end
                S_PREFETCH: begin
                    if (mem_resp) begin
                        mem_read_reg <= 1'b0;
                        ptr_reg      <= ptr_reg + PW'(1);
                        base_reg     <= base_reg + TW'(1);
                        cnt_reg      <= cnt_reg - CW'(1);
                        state_reg    <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

`ifdef PREFETCH_STATS_EN
    logic [DEPTH-1:0] used_reg;

    // Used bit per entry: set on a buffer hit, or at fill when the line is consumed immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            used_reg <= '0;
        end else begin
            if ((state_reg == S_IDLE) && icache_read && hit_any) used_reg[hit_idx] <= 1'b1;
            if (fill_we) used_reg[ptr_reg] <= sim_hit;
        end
    end

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits         <= '0;
            stat_misses       <= '0;
            stat_evict_unused <= '0;
        end else begin
            if ((((state_reg == S_IDLE) && icache_read && hit_any) || sim_hit) && (stat_hits != '1))
                stat_hits <= stat_hits + 32'd1;
            if ((state_reg == S_IDLE) && icache_read && !hit_any && (stat_misses != '1))
                stat_misses <= stat_misses + 32'd1;
            if (fill_we && valid_reg[ptr_reg] && !used_reg[ptr_reg] && (stat_evict_unused != '1))
                stat_evict_unused <= stat_evict_unused + 32'd1;
        end
    end
`endif

endmodule

// File: doc/stream_prefetch_buffer.md
Name: stream_prefetch_buffer

Overview:
- Parametrised next-N-line instruction prefetcher with a small fully-associative prefetch buffer.
- Sits between the I-cache miss port and the I-side memory arbiter port.
- Demand misses that hit the buffer are answered without a memory access.
- Demand misses go to memory, then trigger up to DEGREE sequential line prefetches.
- Prefetches are issued only while the D-cache and I-cache are idle.

Parameters:
- LINE_BYTES, 32, cache line size in bytes (power of 2); OFF = log2(LINE_BYTES).
- DEPTH, 4, buffer entries (power of 2, ≥2).
- DEGREE, 2, lines prefetched ahead of each demand miss (1..DEPTH).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prefetch_enable  in  1  allows prefetch issue; buffer lookup stays active when low.
- icache_read  in  1  I-cache line request, held until icache_resp.
- icache_addr  in  32  request byte address; low OFF bits ignored.
- icache_resp  out  1  one-cycle response pulse.
- icache_rdata  out  8*LINE_BYTES  line data, valid with icache_resp.
- dcache_busy  in  1  D-cache read or write pending; blocks prefetch issue.
- mem_read  out  1  memory read, held until mem_resp.
- mem_addr  out  32  line-aligned address, stable while mem_read is high.
- mem_resp  in  1  one-cycle memory completion.
- mem_rdata  in  8*LINE_BYTES  memory line, valid with mem_resp.

Behaviour:
- Reset (async, rst_n=0):
  - All entries invalid.
  - Replacement pointer = 0; stream counter = 0.
  - FSM = IDLE.
  - icache_resp = 0, mem_read = 0, mem_addr = 0, icache_rdata = 0.
- Entry contents: valid bit, line tag addr[31:OFF], line data.
- Lookup: combinational compare of icache_addr[31:OFF] against all valid tags. At most one entry can match, because insertion is duplicate-suppressed.
- FSM states:
  - IDLE:
    - icache_read with lookup hit -> HIT.
    - icache_read with miss -> DEMAND; mem_addr = aligned icache_addr.
    - No icache_read, stream counter > 0, prefetch_enable=1, dcache_busy=0 -> PF_CHECK.
  - HIT: icache_resp=1 with the entry data for one cycle; entry stays valid -> IDLE. Latency: icache_resp the cycle after icache_read is sampled.
  - DEMAND:
    - mem_read=1 until mem_resp.
    - On mem_resp: icache_resp=1, icache_rdata=mem_rdata in the same cycle.
    - Demand data is not inserted into the buffer.
    - Load stream base = demand line + 1 and stream counter = DEGREE; then -> IDLE.
  - PF_CHECK (one cycle):
    - If the base line is already in the buffer: skip it (base+1, counter-1) -> IDLE.
    - Otherwise latch mem_addr = base<<OFF -> PREFETCH.
  - PREFETCH:
    - mem_read=1 until mem_resp; the request is not aborted.
    - On mem_resp, write the entry at the replacement pointer (valid, tag, data) and increment the pointer mod DEPTH.
    - Then base+1, counter-1 -> IDLE.
    - Simultaneous case: if icache_read is high on the mem_resp cycle and matches the prefetched line, icache_resp=1 with mem_rdata that same cycle (the line is still written).
- Priority in IDLE: demand request > prefetch. A new demand miss reloads the stream base and counter, discarding remaining prefetches.
- Line arithmetic: unsigned on addr[31:OFF]; wraps modulo 2^(32-OFF). Line 0xFFFFFFFF>>OFF + 1 -> line 0.
- Gating:
  - dcache_busy or prefetch_enable=0 holds the FSM in IDLE; the stream counter is kept.
  - prefetch_enable deassert mid-PREFETCH does not abort the request.
- Buffer full: overwrite the oldest entry (FIFO order), no stall.
- Reset mid-transaction: mem_read drops immediately. A late mem_resp while in IDLE with no request is ignored.

Optional Feature:
- Macro: PREFETCH_STATS_EN.
- When defined, three 32-bit outputs are added, each saturating at 0xFFFFFFFF and cleared by reset:
  - stat_hits: HIT responses plus the simultaneous-fill responses.
  - stat_misses: DEMAND entries.
  - stat_evict_unused: overwrite of a valid entry never hit.
- The unused count requires a per-entry used bit.
- When undefined: no counters, no used bits, ports absent.

Test Plan:
- Reset, then icache_read addr 0x1000 -> mem_read with mem_addr 0x1000. After mem_resp: icache_resp the same cycle, then prefetch reads at 0x1020 and 0x1040 (DEGREE=2), each gated by idle inputs.
- After the fills, icache_read 0x1024 -> icache_resp the next cycle with the 0x1020 line data and no mem_read.
- dcache_busy=1 after a demand miss -> no mem_read while it is high. Deassert -> prefetch of base+1 resumes.
- icache_read 0x1040 issued during the in-flight prefetch of 0x1040 -> icache_resp on the same cycle as mem_resp, with no second memory read.
- DEPTH=4: prefetch 5 distinct lines -> the first line is evicted. A request to it goes to DEMAND; with PREFETCH_STATS_EN, stat_evict_unused=1.
- Demand at 0xFFFFFFE0 -> prefetch addresses 0x00000000 and 0x00000020. Assert rst_n=0 during that prefetch -> mem_read=0 immediately and all entries invalid.
